// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants and the rect_fill state encoding.
package vga_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 360;
    localparam int ADDR_WIDTH    = 18;
    localparam int DATA_WIDTH    = 6;
    localparam int X_WIDTH       = 10;
    localparam int Y_WIDTH       = 9;

    // Address distance between vertically adjacent pixels.
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } rf_state_e;

    // Start address of row y; the single multiply in the fill engine.
    function automatic logic [ADDR_WIDTH-1:0] row_base_of(input logic [Y_WIDTH-1:0] y);
        return ADDR_WIDTH'(y) * ROW_STRIDE;
    endfunction

endpackage

// File: rtl/rect_clip.sv
// Combinational corner normalisation with optional screen clipping.
// Clipping is built only when RECT_FILL_CLIP_EN is defined.
module rect_clip
    import vga_pkg::*;
(
    input  logic [X_WIDTH-1:0] x0,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y0,
    input  logic [Y_WIDTH-1:0] y1,
    output logic [X_WIDTH-1:0] xmin,
    output logic [X_WIDTH-1:0] xmax,
    output logic [Y_WIDTH-1:0] ymin,
    output logic [Y_WIDTH-1:0] ymax,
    output logic               empty
);

    logic [X_WIDTH-1:0] xhi_s;
    logic [Y_WIDTH-1:0] yhi_s;

    // Order the corners so min/max hold regardless of how they were given.
    always_comb begin
        if (x0 <= x1) begin
            xmin  = x0;
            xhi_s = x1;
        end else begin
            xmin  = x1;
            xhi_s = x0;
        end
        if (y0 <= y1) begin
            ymin  = y0;
            yhi_s = y1;
        end else begin
            ymin  = y1;
            yhi_s = y0;
        end
    end

`ifdef RECT_FILL_CLIP_EN
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(SCREEN_HEIGHT - 1);

    // Drop rectangles starting off-screen and clamp the far edges to the screen.
    always_comb begin
        empty = (xmin > X_LAST) || (ymin > Y_LAST);
        if (xhi_s > X_LAST) begin
            xmax = X_LAST;
        end else begin
            xmax = xhi_s;
        end
        if (yhi_s > Y_LAST) begin
            ymax = Y_LAST;
        end else begin
            ymax = yhi_s;
        end
    end
`else
    // Unclipped: a normalised rectangle always holds at least one pixel.
    always_comb begin
        empty = 1'b0;
        xmax  = xhi_s;
        ymax  = yhi_s;
    end
`endif

endmodule

// File: rtl/rect_fill.sv
// Rectangle-fill engine: writes one colour index into every pixel of a
// rectangle in the 640x360 VRAM, in raster order, gated by i_wr_ok.
// Optional clipping: define RECT_FILL_CLIP_EN.
module rect_fill
    import vga_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [X_WIDTH-1:0]    i_x0,
    input  logic [X_WIDTH-1:0]    i_x1,
    input  logic [Y_WIDTH-1:0]    i_y0,
    input  logic [Y_WIDTH-1:0]    i_y1,
    input  logic [DATA_WIDTH-1:0] i_colour,
    input  logic                  i_wr_ok,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_write,
    output logic                  o_busy,
    output logic                  o_done
);

    rf_state_e state_r, state_n;

    logic [X_WIDTH-1:0]    x0_r, x1_r, x0_n, x1_n;
    logic [Y_WIDTH-1:0]    y0_r, y1_r, y0_n, y1_n;
    logic [DATA_WIDTH-1:0] colour_r, colour_n;

    // Counters point at the next pixel to write; last_r marks that none remain.
    logic [X_WIDTH-1:0]    x_r, x_n, xmin_r, xmin_n, xmax_r, xmax_n;
    logic [Y_WIDTH-1:0]    y_r, y_n, ymax_r, ymax_n;
    logic [ADDR_WIDTH-1:0] base_r, base_n;
    logic                  last_r, last_n;

    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  write_n, busy_n, done_n;

    logic [X_WIDTH-1:0]    clip_xmin_s, clip_xmax_s;
    logic [Y_WIDTH-1:0]    clip_ymin_s, clip_ymax_s;
    logic                  clip_empty_s;

    logic [X_WIDTH-1:0]    cur_x_s, lim_xmin_s, lim_xmax_s, step_x_s;
    logic [Y_WIDTH-1:0]    cur_y_s, lim_ymax_s, step_y_s;
    logic [ADDR_WIDTH-1:0] cur_base_s, step_base_s;
    logic                  step_last_s;

    rect_clip u_clip (
        .x0    (x0_r),
        .x1    (x1_r),
        .y0    (y0_r),
        .y1    (y1_r),
        .xmin  (clip_xmin_s),
        .xmax  (clip_xmax_s),
        .ymin  (clip_ymin_s),
        .ymax  (clip_ymax_s),
        .empty (clip_empty_s)
    );

    // SETUP issues the first pixel straight from the clip result; FILL uses the counters.
    always_comb begin
        if (state_r == ST_SETUP) begin
            cur_x_s    = clip_xmin_s;
            cur_y_s    = clip_ymin_s;
            cur_base_s = row_base_of(clip_ymin_s);
            lim_xmin_s = clip_xmin_s;
            lim_xmax_s = clip_xmax_s;
            lim_ymax_s = clip_ymax_s;
        end else begin
            cur_x_s    = x_r;
            cur_y_s    = y_r;
            cur_base_s = base_r;
            lim_xmin_s = xmin_r;
            lim_xmax_s = xmax_r;
            lim_ymax_s = ymax_r;
        end
    end

    // Raster-order advance from the current pixel to the next one.
    always_comb begin
        step_x_s    = cur_x_s;
        step_y_s    = cur_y_s;
        step_base_s = cur_base_s;
        step_last_s = 1'b0;
        if (cur_x_s < lim_xmax_s) begin
            step_x_s = cur_x_s + X_WIDTH'(1);
        end else if (cur_y_s < lim_ymax_s) begin
            step_x_s    = lim_xmin_s;
            step_y_s    = cur_y_s + Y_WIDTH'(1);
            step_base_s = cur_base_s + ROW_STRIDE;
        end else begin
            step_last_s = 1'b1;
        end
    end

    // Next-state and next-output logic for the fill FSM.
    always_comb begin
        state_n  = state_r;
        x0_n     = x0_r;
        x1_n     = x1_r;
        y0_n     = y0_r;
        y1_n     = y1_r;
        colour_n = colour_r;
        x_n      = x_r;
        y_n      = y_r;
        base_n   = base_r;
        xmin_n   = xmin_r;
        xmax_n   = xmax_r;
        ymax_n   = ymax_r;
        last_n   = last_r;
        addr_n   = o_addr;
        data_n   = o_data;
        write_n  = 1'b0;
        done_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    x0_n     = i_x0;
                    x1_n     = i_x1;
                    y0_n     = i_y0;
                    y1_n     = i_y1;
                    colour_n = i_colour;
                    state_n  = ST_SETUP;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETUP: begin
                xmin_n = clip_xmin_s;
                xmax_n = clip_xmax_s;
                ymax_n = clip_ymax_s;
                if (clip_empty_s) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else if (i_wr_ok) begin
                    state_n = ST_FILL;
                    write_n = 1'b1;
                    addr_n  = cur_base_s + ADDR_WIDTH'(cur_x_s);
                    data_n  = colour_r;
                    x_n     = step_x_s;
                    y_n     = step_y_s;
                    base_n  = step_base_s;
                    last_n  = step_last_s;
                end else begin
                    state_n = ST_FILL;
                    x_n     = cur_x_s;
                    y_n     = cur_y_s;
                    base_n  = cur_base_s;
                    last_n  = 1'b0;
                end
            end
            ST_FILL: begin
                if (last_r) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else if (i_wr_ok) begin
                    write_n = 1'b1;
                    addr_n  = cur_base_s + ADDR_WIDTH'(cur_x_s);
                    data_n  = colour_r;
                    x_n     = step_x_s;
                    y_n     = step_y_s;
                    base_n  = step_base_s;
                    last_n  = step_last_s;
                end else begin
                    state_n = ST_FILL;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State, working registers and registered VRAM/status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            x0_r     <= '0;
            x1_r     <= '0;
            y0_r     <= '0;
            y1_r     <= '0;
            colour_r <= '0;
            x_r      <= '0;
            y_r      <= '0;
            base_r   <= '0;
            xmin_r   <= '0;
            xmax_r   <= '0;
            ymax_r   <= '0;
            last_r   <= 1'b0;
            o_addr   <= '0;
            o_data   <= '0;
            o_write  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state_r  <= state_n;
            x0_r     <= x0_n;
            x1_r     <= x1_n;
            y0_r     <= y0_n;
            y1_r     <= y1_n;
            colour_r <= colour_n;
            x_r      <= x_n;
            y_r      <= y_n;
            base_r   <= base_n;
            xmin_r   <= xmin_n;
            xmax_r   <= xmax_n;
            ymax_r   <= ymax_n;
            last_r   <= last_n;
            o_addr   <= addr_n;
            o_data   <= data_n;
            o_write  <= write_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// Scoreboard bench for rect_fill: stimulus pushes expected writes, a
// negedge monitor pops and compares every VRAM write it observes.
module tb_rect_fill;
    import vga_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  wr_ok = 1'b1;
    logic [X_WIDTH-1:0]    x0 = '0, x1 = '0;
    logic [Y_WIDTH-1:0]    y0 = '0, y1 = '0;
    logic [DATA_WIDTH-1:0] colour = '0;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_write, o_busy, o_done;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;
    int wr_count = 0;
    int first_wr_cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;

    rect_fill dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_x0     (x0),
        .i_x1     (x1),
        .i_y0     (y0),
        .i_y1     (y1),
        .i_colour (colour),
        .i_wr_ok  (wr_ok),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .o_write  (o_write),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_one(input int addr, input int col);
        exp_q.push_back({addr[17:0], col[5:0]});
    endtask

    // Reference model: raster-order writes for an in-range rectangle.
    task automatic push_rect(input int ax, input int ay, input int bx, input int by, input int col);
        int xl, xh, yl, yh;
        xl = (ax < bx) ? ax : bx;  xh = (ax < bx) ? bx : ax;
        yl = (ay < by) ? ay : by;  yh = (ay < by) ? by : ay;
        for (int yy = yl; yy <= yh; yy++)
            for (int xx = xl; xx <= xh; xx++)
                push_one(yy * 640 + xx, col);
    endtask

    // Monitor: compare every observed write against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_write) begin
                if (wr_count == 0) first_wr_cyc = cyc;
                wr_count++;
                check("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", int'(o_addr), int'(mon_e[23:6]));
                    check("wr_data", int'(o_data), int'(mon_e[5:0]));
                end
            end
            if (o_done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_fill(input int ax, input int ay, input int bx, input int by, input int col,
                            input int exp_writes, input int exp_done_off,
                            input bit stall, input bit restart);
        int n, d0, t;
        @(negedge clk);
        x0 = ax[9:0]; y0 = ay[8:0]; x1 = bx[9:0]; y1 = by[8:0]; colour = col[5:0];
        start = 1'b1;
        n = cyc;
        wr_count = 0;
        d0 = done_seen;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(o_busy), 1);
        while (cyc < n + 3) @(negedge clk);
        if (stall) begin
            wr_ok = 1'b0;
            repeat (3) @(negedge clk);
            wr_ok = 1'b1;
        end
        if (restart) begin
            x0 = 10'd10; y0 = 9'd10; x1 = 10'd20; y1 = 9'd20; colour = 6'd63;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (done_seen == d0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("done_count", done_seen - d0, 1);
        check("done_cycle", done_cyc - n, exp_done_off);
        check("write_count", wr_count, exp_writes);
        if (exp_writes > 0) check("first_write_cycle", first_wr_cyc - n, 2);
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        check("busy_after_done", int'(o_busy), 0);
    endtask

    initial begin
        int n, d0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_write", int'(o_write), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_done", int'(o_done), 0);
        check("reset_addr", int'(o_addr), 0);
        check("reset_data", int'(o_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 2x2 fill.
        push_one(0, 5); push_one(1, 5); push_one(640, 5); push_one(641, 5);
        run_fill(0, 0, 1, 1, 5, 4, 6, 1'b0, 1'b0);

        // Swapped corners on one row.
        push_one(1281, 9); push_one(1282, 9); push_one(1283, 9);
        run_fill(3, 2, 1, 2, 9, 3, 5, 1'b0, 1'b0);

        // Write-permit stall after the second write.
        push_one(0, 5); push_one(1, 5); push_one(640, 5); push_one(641, 5);
        run_fill(0, 0, 1, 1, 5, 4, 9, 1'b1, 1'b0);

        // Second start mid-fill is ignored.
        push_one(0, 1); push_one(1, 1); push_one(2, 1); push_one(3, 1);
        run_fill(0, 0, 3, 0, 1, 4, 6, 1'b0, 1'b1);

        // Reversed 4x4 block, model-generated.
        push_rect(5, 7, 2, 4, 42);
        run_fill(5, 7, 2, 4, 42, 16, 18, 1'b0, 1'b0);

`ifdef RECT_FILL_CLIP_EN
        // Clip against the bottom-right corner.
        for (int yy = 350; yy < 360; yy++)
            for (int xx = 630; xx < 640; xx++)
                push_one(yy * 640 + xx, 7);
        run_fill(630, 350, 700, 400, 7, 100, 102, 1'b0, 1'b0);
        // Fully off-screen rectangle.
        run_fill(700, 0, 710, 5, 3, 0, 2, 1'b0, 1'b0);
`endif

        // Reset in the middle of a fill.
        push_rect(0, 0, 9, 9, 3);
        @(negedge clk);
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd9; y1 = 9'd9; colour = 6'd3;
        start = 1'b1;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 5) @(negedge clk);
        check("writing_before_reset", int'(o_write), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_write", int'(o_write), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        exp_q.delete();
        d0 = done_seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("no_done_after_reset", done_seen - d0, 0);
        check("idle_after_reset", int'(o_busy), 0);

        // New start accepted after reset release.
        push_one(0, 5); push_one(1, 5); push_one(640, 5); push_one(641, 5);
        run_fill(0, 0, 1, 1, 5, 4, 6, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
